maxnet_ctrl_multi: RTL and testbench

//  Parametrised Maxnet iteration controller. Sequences NUM_GROUPS time-multiplexed PLU groups
//  per iteration, counts iterations and stops on convergence, run-time iteration limit, abort,
//  or after one iteration in single-step mode. Drives the Maxnet datapath write enables/mux and

---
 rtl/maxnet_pkg.sv | 52 +++++
 rtl/maxnet_seq_cnt.sv | 31 +++
 rtl/maxnet_ctrl_multi.sv | 160 ++++++++++++++++
 tb/tb_maxnet_ctrl_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet iteration controller.
//   state_t        : controller state encoding
//   strobe_t       : Moore strobe bundle driven to the datapath and host
//   decode_strobes : state -> strobe decode
package maxnet_pkg;

    localparam int unsigned DEFAULT_ITER_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT,
        NEXT_GRP,
        CHECK,
        UPDATE,
        DONE
    } state_t;

    typedef struct packed {
        logic start_plu;
        logic we_a_reg;
        logic we_prim;
        logic eps_reg_we;
        logic mux_sel;
        logic clr;
        logic busy;
        logic finish;
    } strobe_t;

    // Moore decode; IDLE decodes to all-zero so the reset value matches.
    function automatic strobe_t decode_strobes(input state_t s);
        strobe_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            INIT: begin
                o.we_a_reg   = 1'b1;
                o.we_prim    = 1'b1;
                o.eps_reg_we = 1'b1;
                o.mux_sel    = 1'b1;
                o.clr        = 1'b1;
            end
            ISSUE:   o.start_plu = 1'b1;
            UPDATE:  o.we_a_reg  = 1'b1;
            DONE:    o.finish    = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/maxnet_seq_cnt.sv
// Loadable, clearable up-counter that saturates at all-ones.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (highest priority)
//   load/din : synchronous load
//   inc      : count enable
//   q        : counter value
module maxnet_seq_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/maxnet_ctrl_multi.sv
// Maxnet iteration controller: issues NUM_GROUPS PLU groups per iteration,
// counts iterations and stops on convergence, iteration limit, abort or
// after one iteration in single-step mode.
//   inputs  : clk, rst, start, abort, single_step, max_iter, plu_done, valid
//   outputs : start_plu, grp_sel, we_a_reg, we_prim, eps_reg_we, mux_sel, clr,
//             busy, finish, iter_cnt, converged, timeout, aborted
import maxnet_pkg::*;

module maxnet_ctrl_multi #(
    parameter int unsigned NUM_GROUPS = 4,
    parameter int unsigned GRP_W      = 2,
    parameter int unsigned ITER_W     = DEFAULT_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              single_step,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              plu_done,
    input  logic              valid,
    output logic              start_plu,
    output logic [GRP_W-1:0]  grp_sel,
    output logic              we_a_reg,
    output logic              we_prim,
    output logic              eps_reg_we,
    output logic              mux_sel,
    output logic              clr,
    output logic              busy,
    output logic              finish,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              converged,
    output logic              timeout,
    output logic              aborted
);

    localparam int unsigned CNT_W = ITER_W + 1;

    state_t  state;
    state_t  state_d;
    strobe_t strb;

    logic grp_clr, grp_inc, iter_clr, iter_inc;
    logic set_conv, set_tmo, set_abt, clr_status;
    logic last_grp, abort_ok;
    logic [CNT_W-1:0] iter_nxt;
    logic [CNT_W-1:0] eff_max;

    assign last_grp = (grp_sel == GRP_W'(NUM_GROUPS - 1));
    assign abort_ok = abort && (state != IDLE) && (state != DONE);
    // One extra bit so a saturated counter still compares as reaching the limit.
    assign iter_nxt = {1'b0, iter_cnt} + CNT_W'(1);
    assign eff_max  = (max_iter == '0) ? CNT_W'(1) : {1'b0, max_iter};

    // Next-state and counter/status control.
    always_comb begin
        state_d    = state;
        grp_clr    = 1'b0;
        grp_inc    = 1'b0;
        iter_clr   = 1'b0;
        iter_inc   = 1'b0;
        set_conv   = 1'b0;
        set_tmo    = 1'b0;
        set_abt    = 1'b0;
        clr_status = 1'b0;
        case (state)
            IDLE:     if (start) state_d = INIT;
            INIT: begin
                grp_clr    = 1'b1;
                iter_clr   = 1'b1;
                clr_status = 1'b1;
                state_d    = ISSUE;
            end
            ISSUE:    state_d = WAIT;
            WAIT:     if (plu_done) state_d = last_grp ? CHECK : NEXT_GRP;
            NEXT_GRP: begin
                grp_inc = 1'b1;
                state_d = ISSUE;
            end
            CHECK:    state_d = single_step ? DONE : UPDATE;
            UPDATE: begin
                iter_inc = 1'b1;
                if (valid) begin
                    set_conv = 1'b1;
                    state_d  = DONE;
                end else if (iter_nxt >= eff_max) begin
                    set_tmo = 1'b1;
                    state_d = DONE;
                end else begin
                    grp_clr = 1'b1;
                    state_d = ISSUE;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Abort overrides every other exit; INIT still clears for the new run.
        if (abort_ok) begin
            state_d  = DONE;
            set_abt  = 1'b1;
            set_conv = 1'b0;
            set_tmo  = 1'b0;
            grp_inc  = 1'b0;
            iter_inc = 1'b0;
            grp_clr  = (state == INIT);
        end
    end

    // State, registered strobes and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            strb      <= '0;
            converged <= 1'b0;
            timeout   <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state <= state_d;
            strb  <= decode_strobes(state_d);
            if (clr_status) begin
                converged <= 1'b0;
                timeout   <= 1'b0;
                aborted   <= 1'b0;
            end
            if (set_conv) converged <= 1'b1;
            if (set_tmo)  timeout   <= 1'b1;
            if (set_abt)  aborted   <= 1'b1;
        end
    end

    maxnet_seq_cnt #(.W(GRP_W)) u_grp_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (grp_clr),
        .load (1'b0),
        .din  ({GRP_W{1'b0}}),
        .inc  (grp_inc),
        .q    (grp_sel)
    );

    maxnet_seq_cnt #(.W(ITER_W)) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (iter_clr),
        .load (1'b0),
        .din  ({ITER_W{1'b0}}),
        .inc  (iter_inc),
        .q    (iter_cnt)
    );

    assign start_plu  = strb.start_plu;
    assign we_a_reg   = strb.we_a_reg;
    assign we_prim    = strb.we_prim;
    assign eps_reg_we = strb.eps_reg_we;
    assign mux_sel    = strb.mux_sel;
    assign clr        = strb.clr;
    assign busy       = strb.busy;
    assign finish     = strb.finish;

endmodule

// File: tb/tb_maxnet_ctrl_multi.sv
// Bench for maxnet_ctrl_multi: directed table, randomized runs against a
// run-level reference model, and abort / ignored-input / mid-run reset sequences.
module tb_maxnet_ctrl_multi;

    localparam int unsigned NG = 4;
    localparam int unsigned GW = 2;
    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          start_main = 1'b0;
    logic          noise_start = 1'b0;
    logic          abort = 1'b0;
    logic          single_step = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          plu_done = 1'b0;
    logic          valid = 1'b0;
    logic          start_plu;
    logic [GW-1:0] grp_sel;
    logic          we_a_reg, we_prim, eps_reg_we, mux_sel, clr, busy, finish;
    logic [IW-1:0] iter_cnt;
    logic          converged, timeout, aborted;

    assign start = start_main | noise_start;

    maxnet_ctrl_multi #(.NUM_GROUPS(NG), .GRP_W(GW), .ITER_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .single_step(single_step),
        .max_iter   (max_iter),
        .plu_done   (plu_done),
        .valid      (valid),
        .start_plu  (start_plu),
        .grp_sel    (grp_sel),
        .we_a_reg   (we_a_reg),
        .we_prim    (we_prim),
        .eps_reg_we (eps_reg_we),
        .mux_sel    (mux_sel),
        .clr        (clr),
        .busy       (busy),
        .finish     (finish),
        .iter_cnt   (iter_cnt),
        .converged  (converged),
        .timeout    (timeout),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observation counters and PLU responder configuration.
    int pulses = 0, fins = 0, upds = 0, inits = 0;
    int grp_log[$];
    int cyc = 0, start_cyc = 0, first_plu_cyc = -1;
    int cd = 0;
    int cfg_delay = 0;
    int cfg_vi = 0;
    int cfg_abort_grp = -1;
    int cfg_stall_at = 0;
    bit cfg_noise = 1'b0;

    // Monitor + PLU/winner-detect responder, acting between clock edges.
    always @(negedge clk) begin
        cyc++;
        plu_done    = 1'b0;
        abort       = 1'b0;
        noise_start = 1'b0;
        valid       = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (finish) fins++;
            if (we_a_reg && mux_sel) inits++;
            if (we_a_reg && !mux_sel) begin
                upds++;
                valid = (cfg_vi != 0) && (upds == cfg_vi);
            end
            if (start_plu) begin
                pulses++;
                grp_log.push_back(int'(grp_sel));
                if (first_plu_cyc < 0) first_plu_cyc = cyc;
                if (cfg_stall_at != 0 && pulses >= cfg_stall_at) cd = 0;
                else cd = 1 + int'($urandom_range(0, cfg_delay));
                if (cfg_noise) begin
                    plu_done    = 1'b1;
                    noise_start = 1'b1;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    plu_done = 1'b1;
                    if (int'(grp_sel) == cfg_abort_grp) abort = 1'b1;
                end
            end
        end
    end

    task automatic run_and_check(input string tag, input int ms, input bit ss, input int vi,
                                 input int exp_iter, input bit exp_conv, input bit exp_tmo,
                                 input bit exp_abt, input int exp_pulses);
        int waited;
        int bad;
        @(negedge clk); #1;
        pulses = 0; fins = 0; upds = 0; inits = 0;
        grp_log.delete();
        first_plu_cyc = -1;
        cfg_vi      = vi;
        max_iter    = IW'(ms);
        single_step = ss;
        start_main  = 1'b1;
        start_cyc   = cyc;
        @(negedge clk); #1;
        start_main = 1'b0;
        waited = 0;
        while (fins == 0 && waited < 3000) begin
            @(negedge clk); #1;
            waited++;
        end
        check({tag, "_finish_seen"}, longint'(fins > 0), 1);
        repeat (2) begin @(negedge clk); #1; end
        check({tag, "_finish_count"}, fins, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_iter_cnt"}, iter_cnt, exp_iter);
        check({tag, "_converged"}, converged, exp_conv);
        check({tag, "_timeout"}, timeout, exp_tmo);
        check({tag, "_aborted"}, aborted, exp_abt);
        check({tag, "_start_plu_pulses"}, pulses, exp_pulses);
        bad = 0;
        foreach (grp_log[i]) if (grp_log[i] != (i % NG)) bad++;
        check({tag, "_grp_order_errors"}, bad, 0);
        check({tag, "_init_cycles"}, inits, 1);
        check({tag, "_update_cycles"}, upds, exp_iter);
        check({tag, "_latency"}, first_plu_cyc - start_cyc, 2);
    endtask

    typedef struct {
        int ms;
        bit ss;
        int vi;
        int exp_iter;
        bit exp_conv;
        bit exp_tmo;
        int exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ms, vi, eff, it, p;
        bit ss, cv, tm;
        int waited;

        // Directed vectors: {max_iter, single_step, valid_iter, iter, conv, tmo, pulses}
        vecs[0] = '{10, 1'b0, 3, 3, 1'b1, 1'b0, 12};
        vecs[1] = '{5,  1'b0, 0, 5, 1'b0, 1'b1, 20};
        vecs[2] = '{0,  1'b0, 0, 1, 1'b0, 1'b1, 4};
        vecs[3] = '{10, 1'b1, 1, 0, 1'b0, 1'b0, 4};
        vecs[4] = '{2,  1'b0, 2, 2, 1'b1, 1'b0, 8};
        vecs[5] = '{1,  1'b0, 1, 1, 1'b1, 1'b0, 4};

        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_busy", busy, 0);
        check("reset_grp_sel", grp_sel, 0);
        check("reset_iter_cnt", iter_cnt, 0);
        check("reset_status", {converged, timeout, aborted}, 0);
        check("reset_strobes", {start_plu, we_a_reg, we_prim, eps_reg_we, mux_sel, clr, finish}, 0);
        #9 rst = 1'b0;

        foreach (vecs[i]) begin
            cfg_delay = i % 3;
            run_and_check($sformatf("vec%0d", i), vecs[i].ms, vecs[i].ss, vecs[i].vi,
                          vecs[i].exp_iter, vecs[i].exp_conv, vecs[i].exp_tmo, 1'b0,
                          vecs[i].exp_pulses);
        end

        // Randomized runs against the run-level reference model.
        for (int k = 0; k < 20; k++) begin
            ms = int'($urandom_range(0, 6));
            ss = ($urandom_range(0, 4) == 0);
            vi = int'($urandom_range(0, 8));
            cfg_delay = int'($urandom_range(0, 3));
            eff = (ms == 0) ? 1 : ms;
            cv = 1'b0; tm = 1'b0;
            if (ss) begin
                it = 0;
            end else if (vi != 0 && vi <= eff) begin
                it = vi; cv = 1'b1;
            end else begin
                it = eff; tm = 1'b1;
            end
            p = ss ? NG : NG * it;
            run_and_check($sformatf("rnd%0d", k), ms, ss, vi, it, cv, tm, 1'b0, p);
        end

        // Abort coincident with plu_done on group 2 of the first iteration.
        cfg_delay = 1;
        cfg_abort_grp = 2;
        run_and_check("abort_wait_g2", 10, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3);
        cfg_abort_grp = -1;

        // start and plu_done pulsed during every ISSUE must be ignored.
        cfg_noise = 1'b1;
        run_and_check("noise_issue", 2, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0, 8);
        cfg_noise = 1'b0;

        // Asynchronous reset while waiting on group 1 of the second iteration.
        cfg_stall_at = NG + 2;
        @(negedge clk); #1;
        fins = 0; pulses = 0; upds = 0; inits = 0;
        cfg_vi = 0;
        max_iter = IW'(10);
        single_step = 1'b0;
        start_main = 1'b1;
        @(negedge clk); #1;
        start_main = 1'b0;
        waited = 0;
        while (pulses < int'(NG) + 2 && waited < 500) begin
            @(negedge clk); #1;
            waited++;
        end
        @(negedge clk); #1;
        check("midrun_busy_before_rst", busy, 1);
        check("midrun_grp_before_rst", grp_sel, 1);
        check("midrun_iter_before_rst", iter_cnt, 1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_grp_sel", grp_sel, 0);
        check("midrun_rst_iter_cnt", iter_cnt, 0);
        check("midrun_rst_strobes", {start_plu, we_a_reg, we_prim, mux_sel, clr, finish}, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        cfg_stall_at = 0;
        repeat (2) begin @(negedge clk); #1; end
        check("midrun_no_finish", fins, 0);
        check("midrun_idle_after", busy, 0);
        run_and_check("after_rst", 1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
